// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, synchronized rows,
// press/release debounce, key code with one-cycle valid. Optional macro: KEYPAD_HEXMAP_EN.
module module_keypad_scanner #(
  parameter int unsigned FREQUENCY      = 27_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TICK_MAX = FREQUENCY / SCAN_HZ;
  localparam int unsigned CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    WAIT_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_m_q, row_m_d;
  logic [3:0]       row_s_q, row_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       cap_row_q, cap_row_d;
  logic [1:0]       cap_col_q, cap_col_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             tick;
  logic             pressed;
  logic [1:0]       prow;
  logic [1:0]       col_idx;

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
`ifdef KEYPAD_HEXMAP_EN
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
`else
    return {r, c};
`endif
  endfunction

  assign tick    = (cnt_q == CNT_LAST);
  assign pressed = (row_s_q != 4'hF);

  // Lowest-numbered active row wins when several keys share the column.
  always_comb begin
    prow = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_s_q[3 - i]) prow = 2'(3 - i);
    end
  end

  always_comb begin
    unique case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    row_m_d     = row_in;
    row_s_d     = row_m_q;
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    state_d     = state_q;
    deb_d       = deb_q;
    col_d       = col_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (pressed) begin
            cap_row_d = prow;
            cap_col_d = col_idx;
            deb_d     = DEB_W'(1);
            state_d   = DEBOUNCE;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end
        DEBOUNCE: begin
          if (!row_s_q[cap_row_q]) begin
            if (deb_q == DEB_LAST) begin
              key_code_d  = map_key(cap_row_q, cap_col_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_d       = '0;
              state_d     = WAIT_RELEASE;
            end else begin
              deb_d = deb_q + DEB_W'(1);
            end
          end else begin
            deb_d   = '0;
            state_d = SCAN;
          end
        end
        WAIT_RELEASE: begin
          if (!pressed) begin
            if (deb_q == DEB_LAST) begin
              key_held_d = 1'b0;
              deb_d      = '0;
              state_d    = SCAN;
              col_d      = {col_q[2:0], col_q[3]};
            end else begin
              deb_d = deb_q + DEB_W'(1);
            end
          end else begin
            deb_d = '0;
          end
        end
        default: begin
          deb_d   = '0;
          state_d = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      row_m_q     <= '1;
      row_s_q     <= '1;
      cnt_q       <= '0;
      deb_q       <= '0;
      col_q       <= 4'b1110;
      cap_row_q   <= '0;
      cap_col_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_m_q     <= row_m_d;
      row_s_q     <= row_s_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      col_q       <= col_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/module_keypad_scanner.md
Name: module_keypad_scanner

Overview:
- Reads a 4x4 passive matrix keypad by stepping a one-hot active-low column drive at a fixed rate, in the same way the display controller steps its digit anodes.
- Samples the four row lines, debounces the detected key and emits a 4-bit key code with a one-cycle valid pulse.
- Sits between the keypad pins and the input/arithmetic logic that feeds the 7-segment display path.

Parameters:
- FREQUENCY, 27_000_000, input clock frequency in Hz
- SCAN_HZ, 1000, column step / sample tick rate in Hz; TICK_MAX = FREQUENCY/SCAN_HZ clocks per tick
- DEBOUNCE_TICKS, 20, consecutive stable ticks required for both press and release (min 2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- row_in  input  4  keypad rows, active-low (external pull-ups); bit i = row i
- col_out  output  4  column drive, one-hot active-low; bit j = column j
- key_code  output  4  code of last accepted key
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_held  output  1  high from acceptance until debounced release

Behaviour:
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, tick and debounce counters 0, synchronizer flops 4'b1111. Reset is honoured at any point, including mid-debounce; no key_valid is produced afterwards for a key that was not re-debounced.
- row_in passes through a 2-flop synchronizer (row_s) before any use; this adds 2 clocks of latency.
- Tick counter runs 0..TICK_MAX-1 and wraps. tick=1 on the cycle where count==TICK_MAX-1. All state decisions are made only on tick cycles.
- pressed = (row_s != 4'hF). prow = index of the lowest-numbered low bit of row_s; this is the multi-key priority.
- SCAN:
  - On tick with pressed: capture prow and the current column into cap_row/cap_col, set deb=1, go to DEBOUNCE. col_out is not advanced.
  - On tick with no key: rotate the column 1110->1101->1011->0111->1110.
- DEBOUNCE (col_out frozen):
  - On tick, if row_s[cap_row]==0, deb++.
  - When deb reaches DEBOUNCE_TICKS: on that tick edge, load key_code, pulse key_valid for exactly one clock, set key_held=1, go to WAIT_RELEASE.
  - On tick with row_s[cap_row]==1 (bounce): deb=0, return to SCAN, no output change, column not advanced on that tick.
- WAIT_RELEASE (col_out frozen):
  - On tick, if row_s==4'hF, deb++; any tick with a key present clears deb to 0.
  - When deb reaches DEBOUNCE_TICKS: key_held=0, go to SCAN, advance the column on that tick.
  - No second key_valid is issued while in this state. Pressing another key while one is held is ignored.
- key_code holds its value until the next acceptance.
- Default raw code: key_code = {cap_row[1:0], cap_col[1:0]}, i.e. row*4+col.
- Minimum press-to-valid latency: 2 sync clocks, plus wait to the next tick, plus (DEBOUNCE_TICKS-1) ticks.

Optional Feature:
- Macro KEYPAD_HEXMAP_EN.
- Defined: key_code is translated through the standard keypad legend:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E(*),0,F(#),D
- Undefined: key_code is the raw row*4+col. All timing is identical in both builds.

Test Plan (bench uses FREQUENCY=1000, SCAN_HZ=100 so TICK_MAX=10, and DEBOUNCE_TICKS=3):
- Reset mid-count, no key pressed -> col_out=1110 immediately; col_out then steps 1101, 1011, 0111, 1110 at 10-clock intervals; key_valid stays 0.
- Clean press of row1 whenever col_out==0111 (col 3), held 100 clocks -> exactly one key_valid pulse 2 ticks after detection; key_code=7 raw or 4'hB with KEYPAD_HEXMAP_EN; key_held=1; col_out stays 0111.
- Bounce: row2 low for 1 tick at col 0, then high -> no key_valid; return to SCAN; key_code unchanged (0 after reset).
- Release: after accepting a key, release with one 1-tick glitch low, then stay high -> key_held drops only 3 stable ticks after the glitch; scan resumes from the next column.
- Simultaneous row0 and row3 low at col 1 -> key_code=1 raw or 4'h2 mapped (row0 priority); a single pulse.
- Assert rst while in DEBOUNCE (deb=2) -> all outputs return to reset values; no key_valid follows unless the key is re-debounced for a full 3 ticks.
